// File: rtl/cache_pkg.sv
// Shared constants for the instruction-cache line refill engine: line geometry,
// address field positions and FSM state encoding.
package cache_pkg;

   localparam int LINE_WORDS = 4;
   localparam int WORD_BITS  = 32;
   localparam int LINE_BITS  = 128;

   localparam int OFF_LSB  = 2;
   localparam int OFF_MSB  = 3;
   localparam int BASE_LSB = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/cache_line_fill.sv
// Instruction-cache line refill: fetches four 32-bit words and presents one 128-bit line.
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN for critical-word-first order and the early word path.
module cache_line_fill #(
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     miss,
   input  logic [ADDR_W-1:0]        miss_address,
   output logic                     mem_read,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_ready,
   input  logic [31:0]              mem_data,
   output logic [LINE_WORDS*32-1:0] data_line,
   output logic                     line_valid,
   output logic [ADDR_W-1:0]        line_address,
   output logic                     busy,
   output logic                     crit_valid,
   output logic [31:0]              crit_word
);
   import cache_pkg::*;

   logic [1:0]                r_state;
   logic [1:0]                r_cnt;
   logic [ADDR_W-1:BASE_LSB]  r_base;
   logic [LINE_WORDS*32-1:0]  r_line;
   logic [ADDR_W-1:0]         r_line_addr;
   logic [1:0]                w_idx;
   logic                      w_fetch;
   logic                      w_accept;

   assign w_fetch  = (r_state == ST_FETCH);
   assign w_accept = w_fetch & mem_ready;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   logic [1:0] r_off;
   logic [1:0] w_unused_addr;

   // The counter counts accepted words; the slot wraps around from the missed word.
   assign w_idx         = r_off + r_cnt;
   assign crit_valid    = w_accept & (r_cnt == 2'd0);
   assign crit_word     = crit_valid ? mem_data : 32'd0;
   assign w_unused_addr = miss_address[1:0];

   always_ff @(posedge clock) begin
      if (reset)
         r_off <= 2'd0;
      else if ((r_state == ST_IDLE) && miss)
         r_off <= miss_address[OFF_MSB:OFF_LSB];
   end
`else
   logic [3:0] w_unused_addr;

   assign w_idx         = r_cnt;
   assign crit_valid    = 1'b0;
   assign crit_word     = 32'd0;
   assign w_unused_addr = miss_address[OFF_MSB:0];
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 2'd0;
         r_base      <= '0;
         r_line      <= '0;
         r_line_addr <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (miss) begin
                  r_state <= ST_FETCH;
                  r_base  <= miss_address[ADDR_W-1:BASE_LSB];
                  r_cnt   <= 2'd0;
               end
            end
            ST_FETCH: begin
               if (mem_ready) begin
                  r_line[WORD_BITS*w_idx +: WORD_BITS] <= mem_data;
                  r_cnt <= r_cnt + 2'd1;
                  // line_address only moves when the line it describes is complete
                  if (r_cnt == 2'd3) begin
                     r_state     <= ST_DONE;
                     r_line_addr <= {r_base, {BASE_LSB{1'b0}}};
                  end
               end
            end
            ST_DONE:  r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy         = (r_state != ST_IDLE);
   assign mem_read     = w_fetch;
   assign mem_addr     = w_fetch ? {r_base, w_idx, 2'b00} : '0;
   assign line_valid   = (r_state == ST_DONE);
   assign data_line    = r_line;
   assign line_address = r_line_addr;

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill; memory model returns addr ^ 0xA5A5A5A5.
module tb_cache_line_fill;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif
   localparam logic [31:0] PAT = 32'hA5A5A5A5;

   logic         clock = 1'b0;
   logic         reset;
   logic         miss;
   logic [31:0]  miss_address;
   logic         mem_read;
   logic [31:0]  mem_addr;
   logic         mem_ready;
   logic [31:0]  mem_data;
   logic [127:0] data_line;
   logic         line_valid;
   logic [31:0]  line_address;
   logic         busy;
   logic         crit_valid;
   logic [31:0]  crit_word;

   int total = 0;
   int bad   = 0;

   cache_line_fill dut (
      .clock(clock), .reset(reset), .miss(miss), .miss_address(miss_address),
      .mem_read(mem_read), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
      .data_line(data_line), .line_valid(line_valid), .line_address(line_address),
      .busy(busy), .crit_valid(crit_valid), .crit_word(crit_word)
   );

   always #5 clock = ~clock;
   assign mem_data = mem_addr ^ PAT;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] exp_addr(input logic [31:0] a, input int k);
      logic [1:0] off;
      logic [1:0] idx;
      off = a[3:2];
      idx = CWF ? 2'(off + k) : 2'(k);
      return {a[31:4], 4'b0} + 32'(idx) * 4;
   endfunction

   task automatic test_reset();
      reset = 1'b1; miss = 1'b0; miss_address = 32'h0; mem_ready = 1'b0;
      step(); step();
      total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL rst_mem_read got=%b want=0", mem_read); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
      total++; if (data_line !== 128'h0) begin bad++; $display("FAIL rst_data_line got=%h want=0", data_line); end
      total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL rst_line_valid got=%b want=0", line_valid); end
      total++; if (line_address !== 32'h0) begin bad++; $display("FAIL rst_line_address got=%h want=0", line_address); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if ({crit_valid, crit_word} !== 33'h0) begin bad++; $display("FAIL rst_crit got=%b/%h want=0/0", crit_valid, crit_word); end
      reset = 1'b0;
      mem_ready = 1'b1;
      step();
      total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL idle_ready_ignored got=%b want=0", mem_read); end
   endtask

   task automatic test_basic();
      miss = 1'b1; miss_address = 32'h84; mem_ready = 1'b1;
      step();
      miss = 1'b0;
      for (int k = 0; k < 4; k++) begin
         total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL basic_mem_read[%0d] got=%b want=1", k, mem_read); end
         total++; if (mem_addr !== exp_addr(32'h84, k)) begin bad++; $display("FAIL basic_mem_addr[%0d] got=%h want=%h", k, mem_addr, exp_addr(32'h84, k)); end
         total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid[%0d] got=%b want=0", k, line_valid); end
         step();
      end
      total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_T5 got=%b want=1", line_valid); end
      total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL basic_done_read got=%b want=0", mem_read); end
      total++; if (line_address !== 32'h80) begin bad++; $display("FAIL basic_line_address got=%h want=00000080", line_address); end
      total++; if (data_line[63:32] !== 32'hA5A5A521) begin bad++; $display("FAIL basic_word1 got=%h want=a5a5a521", data_line[63:32]); end
      total++; if (data_line !== {32'hA5A5A529, 32'hA5A5A52D, 32'hA5A5A521, 32'hA5A5A525}) begin bad++; $display("FAIL basic_line got=%h", data_line); end
      step();
      total++; if ({line_valid, busy} !== 2'b00) begin bad++; $display("FAIL basic_after_done got=%b want=00", {line_valid, busy}); end
      total++; if (data_line[31:0] !== 32'hA5A5A525 || line_address !== 32'h80) begin bad++; $display("FAIL basic_hold got=%h/%h", data_line[31:0], line_address); end
   endtask

   task automatic test_crit();
      miss = 1'b1; miss_address = 32'h1AC; mem_ready = 1'b1;
      step();
      miss = 1'b0;
      total++; if (crit_valid !== CWF) begin bad++; $display("FAIL crit_valid_T1 got=%b want=%b", crit_valid, CWF); end
      total++; if (crit_word !== (CWF ? 32'hA5A5A409 : 32'h0)) begin bad++; $display("FAIL crit_word got=%h want=%h", crit_word, CWF ? 32'hA5A5A409 : 32'h0); end
      for (int k = 0; k < 4; k++) begin
         total++; if (mem_addr !== exp_addr(32'h1AC, k)) begin bad++; $display("FAIL crit_mem_addr[%0d] got=%h want=%h", k, mem_addr, exp_addr(32'h1AC, k)); end
         step();
         if (k == 0) begin
            total++; if (crit_valid !== 1'b0) begin bad++; $display("FAIL crit_one_pulse got=%b want=0", crit_valid); end
         end
      end
      total++; if (line_valid !== 1'b1 || line_address !== 32'h1A0) begin bad++; $display("FAIL crit_done got=%b/%h want=1/000001a0", line_valid, line_address); end
      total++; if (data_line[127:96] !== 32'hA5A5A409 || data_line[31:0] !== (32'h1A0 ^ PAT)) begin bad++; $display("FAIL crit_line got=%h", data_line); end
      step();
   endtask

   task automatic test_stall();
      int acc = 0;
      int pulses = 0;
      miss = 1'b1; miss_address = 32'h100; mem_ready = 1'b1;
      step();
      miss = 1'b0;
      for (int c = 0; c < 30; c++) begin
         mem_ready = (c % 3 == 0);
         #1;
         if (mem_read) begin
            total++; if (mem_addr !== exp_addr(32'h100, acc)) begin bad++; $display("FAIL stall_addr[c%0d] got=%h want=%h", c, mem_addr, exp_addr(32'h100, acc)); end
            if (mem_ready) acc++;
         end
         if (line_valid) pulses++;
         step();
      end
      mem_ready = 1'b1;
      total++; if (acc !== 4) begin bad++; $display("FAIL stall_accepted got=%0d want=4", acc); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL stall_pulses got=%0d want=1", pulses); end
      total++; if (data_line !== {32'h10C ^ PAT, 32'h108 ^ PAT, 32'h104 ^ PAT, 32'h100 ^ PAT}) begin bad++; $display("FAIL stall_line got=%h", data_line); end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      miss = 1'b1; miss_address = 32'h240; mem_ready = 1'b1;
      step();
      miss = 1'b0;
      step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++; if ({mem_read, line_valid, busy, crit_valid} !== 4'b0) begin bad++; $display("FAIL midrst_ctrl got=%b want=0000", {mem_read, line_valid, busy, crit_valid}); end
      total++; if (mem_addr !== 32'h0 || line_address !== 32'h0 || crit_word !== 32'h0) begin bad++; $display("FAIL midrst_addr got=%h/%h/%h want=0", mem_addr, line_address, crit_word); end
      total++; if (data_line !== 128'h0) begin bad++; $display("FAIL midrst_line got=%h want=0", data_line); end
      for (int c = 0; c < 6; c++) begin
         if (line_valid) pulses++;
         step();
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_no_valid got=%0d want=0", pulses); end
      miss = 1'b1; miss_address = 32'h84;
      step();
      miss = 1'b0;
      step(); step(); step(); step();
      total++; if (line_valid !== 1'b1 || line_address !== 32'h80) begin bad++; $display("FAIL midrst_refill got=%b/%h want=1/00000080", line_valid, line_address); end
      total++; if (data_line[63:32] !== 32'hA5A5A521) begin bad++; $display("FAIL midrst_word1 got=%h want=a5a5a521", data_line[63:32]); end
      step();
   endtask

   task automatic test_back_to_back();
      miss = 1'b1; miss_address = 32'h200; mem_ready = 1'b1;
      step();
      miss = 1'b0;
      step();
      miss = 1'b1; miss_address = 32'h300;
      step();
      miss = 1'b0;
      total++; if (mem_addr !== 32'h208) begin bad++; $display("FAIL b2b_pulse_ignored got=%h want=00000208", mem_addr); end
      step();
      miss = 1'b1; miss_address = 32'h400;
      total++; if (mem_addr !== 32'h20C) begin bad++; $display("FAIL b2b_last_word got=%h want=0000020c", mem_addr); end
      step();
      total++; if (line_valid !== 1'b1 || line_address !== 32'h200 || busy !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b/%h/%b", line_valid, line_address, busy); end
      step();
      total++; if ({busy, line_valid, mem_read} !== 3'b000) begin bad++; $display("FAIL b2b_idle got=%b want=000", {busy, line_valid, mem_read}); end
      step();
      miss = 1'b0;
      total++; if (busy !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 32'h400) begin bad++; $display("FAIL b2b_restart got=%b/%b/%h want=1/1/00000400", busy, mem_read, mem_addr); end
      step(); step(); step(); step();
      total++; if (line_valid !== 1'b1 || line_address !== 32'h400) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/00000400", line_valid, line_address); end
      total++; if (data_line[127:96] !== 32'hA5A5A1A9) begin bad++; $display("FAIL b2b_word3 got=%h want=a5a5a1a9", data_line[127:96]); end
      step();
   endtask

   initial begin
      reset = 1'b1; miss = 1'b0; miss_address = 32'h0; mem_ready = 1'b0;
      test_reset();
      test_basic();
      test_crit();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_line_fill.md
CACHE_LINE_FILL -- requirements
Module: cache_line_fill

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter ADDR_W, default 32: address width in bits.
REQ-003 Parameter LINE_WORDS, default 4: 32-bit words per line; only 4 is supported.
REQ-004 Port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port miss, input, 1 bit: the cache requests a line refill.
REQ-007 Port miss_address, input, 32 bits: the instruction address that missed.
REQ-008 Port mem_read, output, 1 bit: word read request to instruction memory.
REQ-009 Port mem_addr, output, 32 bits: byte address of the requested word.
REQ-010 Port mem_ready, input, 1 bit: memory presents a valid mem_data this cycle.
REQ-011 Port mem_data, input, 32 bits: the returned word.
REQ-012 Port data_line, output, 128 bits: the assembled line sent to the cache.
REQ-013 Port line_valid, output, 1 bit: one-cycle pulse; data_line is complete.
REQ-014 Port line_address, output, 32 bits: line base address matching data_line.
REQ-015 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 Port crit_valid, output, 1 bit, and port crit_word, output, 32 bits: the early requested-word path (see Configuration).

Function
REQ-017 Line base SHALL be {miss_address[31:4], 4'b0000}; word offset SHALL be miss_address[3:2]; bits [1:0] are ignored.
REQ-018 Word i SHALL occupy data_line[32*i+31 : 32*i].
REQ-019 States SHALL be IDLE, FETCH and DONE.
REQ-020 IDLE -> FETCH: when miss=1, latch base and offset, clear the word counter.
REQ-021 IDLE while miss=0: stay in IDLE.
REQ-022 FETCH SHALL hold mem_read=1 with mem_addr = base + 4*word_index, stable until mem_ready=1.
REQ-023 Each FETCH cycle with mem_ready=1 SHALL write mem_data into its slot and advance the 2-bit counter.
REQ-024 FETCH -> DONE: on the 4th accepted word.
REQ-025 FETCH cycles with mem_ready=0 SHALL be stalls that change nothing.
REQ-026 DONE SHALL assert line_valid for exactly one cycle, with data_line and line_address stable, then return to IDLE.
REQ-027 Minimum latency: miss sampled at edge T; mem_read high from T+1; with mem_ready tied 1, line_valid is high in cycle T+5.
REQ-028 miss SHALL be ignored in FETCH and DONE; a miss held high through DONE starts a new fill on the following IDLE cycle.
REQ-029 data_line and line_address SHALL hold their values after DONE until the next fill overwrites them.
REQ-030 mem_read SHALL be 0 in IDLE and DONE; mem_ready SHALL be ignored outside FETCH.

Reset
REQ-031 Reset SHALL force IDLE and clear the counter; mem_read, mem_addr, data_line, line_valid, line_address, busy, crit_valid and crit_word SHALL all be 0.
REQ-032 Reset during FETCH or DONE SHALL abort the fill with no line_valid pulse; reset has priority over miss.

Configuration
REQ-033 Macro CACHE_FILL_CRITICAL_WORD_FIRST_EN SHALL select critical-word-first fill.
REQ-034 With the macro defined: fetch order is offset, offset+1, ... modulo 4, wrapping within the line; crit_valid pulses for one cycle with crit_word = mem_data when the first word is accepted.
REQ-035 Without the macro: fetch order is always 0, 1, 2, 3; crit_valid and crit_word are tied 0.

Structure
REQ-036 Shared package cache_pkg SHALL hold LINE_WORDS, LINE_BITS=128, the state encoding and the line-base/offset field positions.
REQ-037 No sub-module: the block is one module containing the FSM, the counter and the line register.

Verification
REQ-038 miss_address=0x84, mem_ready=1, memory returns addr^0xA5A5A5A5, macro off -> mem_addr sequence 0x80, 0x84, 0x88, 0x8C; line_valid at T+5; line_address=0x80; data_line word1 = 0xA5A5A521.
REQ-039 miss_address=0x1AC, macro on -> mem_addr sequence 0x1AC, 0x1A0, 0x1A4, 0x1A8; crit_valid at T+1 with crit_word=0xA5A5A409; line_address=0x1A0.
REQ-040 mem_ready toggling 1,0,0,1,... during a fill -> mem_addr held during stalls; exactly 4 words accepted; exactly one line_valid pulse.
REQ-041 Reset asserted in FETCH after 2 words -> all outputs 0 on the next cycle; no line_valid; a later miss at 0x84 fills correctly.
REQ-042 Second miss pulsed during FETCH, miss held high through DONE -> the pulsed miss is ignored; the held miss starts a new fill in the cycle after DONE with busy=1.
